// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sequencing the board SRAM between the recorder (write)
// and player (read) ports; every access is followed by an IDLE turnaround cycle.
module sram_access_arbiter #(
  parameter int ACC_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_req,
  input  logic [19:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_ack,
  input  logic        i_rd_req,
  input  logic [19:0] i_rd_addr,
  output logic        o_rd_ack,
  output logic [15:0] o_rd_data,
  output logic        o_busy,
  output logic [19:0] o_sram_addr,
  inout  wire  [15:0] io_sram_dq,
  output logic        o_sram_ce,
  output logic        o_sram_oe,
  output logic        o_sram_we,
  output logic        o_sram_lb,
  output logic        o_sram_ub
);

  localparam int CNT_W = $clog2(ACC_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WHOLD = 3'd2,
    S_READ  = 3'd3,
    S_RDONE = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_rd;
  logic              r_dq_oe;
  logic [15:0]       r_wr_data;
  logic              w_grant_wr;

  // A tie goes to whichever port was not served last.
  assign w_grant_wr = i_wr_req && (!i_rd_req || r_last_rd);
  assign io_sram_dq = r_dq_oe ? r_wr_data : 16'bz;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_rd   <= 1'b1;
      r_dq_oe     <= 1'b0;
      o_sram_ce   <= 1'b1;
      o_sram_oe   <= 1'b1;
      o_sram_we   <= 1'b1;
      o_sram_lb   <= 1'b1;
      o_sram_ub   <= 1'b1;
      o_wr_ack    <= 1'b0;
      o_rd_ack    <= 1'b0;
      o_rd_data   <= '0;
      o_sram_addr <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_wr_ack <= 1'b0;
      o_rd_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_wr_req || i_rd_req) begin
            r_cnt     <= '0;
            o_busy    <= 1'b1;
            o_sram_ce <= 1'b0;
            o_sram_lb <= 1'b0;
            o_sram_ub <= 1'b0;
            if (w_grant_wr) begin
              r_state     <= S_WRITE;
              r_last_rd   <= 1'b0;
              o_sram_addr <= i_wr_addr;
              r_wr_data   <= i_wr_data;
              o_sram_we   <= 1'b0;
              r_dq_oe     <= 1'b1;
            end else begin
              r_state     <= S_READ;
              r_last_rd   <= 1'b1;
              o_sram_addr <= i_rd_addr;
              o_sram_oe   <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          if (r_cnt == LAST_CNT) begin
            r_state   <= S_WHOLD;
            o_sram_we <= 1'b1;
            o_wr_ack  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // Data stays on the bus one cycle past the WE rising edge for hold time.
        S_WHOLD: begin
          r_state   <= S_IDLE;
          o_busy    <= 1'b0;
          o_sram_ce <= 1'b1;
          o_sram_lb <= 1'b1;
          o_sram_ub <= 1'b1;
          r_dq_oe   <= 1'b0;
        end
        S_READ: begin
          if (r_cnt == LAST_CNT) begin
            r_state   <= S_RDONE;
            o_rd_data <= io_sram_dq;
            o_rd_ack  <= 1'b1;
            o_sram_oe <= 1'b1;
            o_sram_ce <= 1'b1;
            o_sram_lb <= 1'b1;
            o_sram_ub <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RDONE: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Randomized bench for sram_access_arbiter: cycle-level access-phase model,
// shadow memory for read data, and an SRAM behavioural model on the DQ bus.
module tb_sram_access_arbiter;

  localparam int ACC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [19:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  wire         wr_ack, rd_ack, busy, ce, oe, we, lb, ub;
  wire  [15:0] rd_data;
  wire  [19:0] sram_addr;
  wire  [15:0] dq;

  always #5 clk = ~clk;

  sram_access_arbiter #(.ACC_CYCLES(ACC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack), .o_rd_data(rd_data),
    .o_busy(busy), .o_sram_addr(sram_addr), .io_sram_dq(dq),
    .o_sram_ce(ce), .o_sram_oe(oe), .o_sram_we(we), .o_sram_lb(lb), .o_sram_ub(ub)
  );

  function automatic logic [15:0] dflt(input logic [19:0] a);
    return a[15:0] ^ 16'h5A5A ^ {12'h0, a[19:16]};
  endfunction

  // SRAM model: drives DQ on a read, stores DQ mid-cycle while written
  logic [15:0] mem [0:(1<<20)-1];
  assign dq = (!ce && !oe && we) ? mem[sram_addr] : 16'bz;
  initial begin
    for (int i = 0; i < (1 << 20); i++) mem[i] = dflt(20'(i));
    forever begin
      @(negedge clk);
      if (!ce && !we && !lb && !ub) mem[sram_addr] = dq;
    end
  end

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: access phase 1..ACC strobes, ACC+1 ack, then idle
  bit          m_act, m_wr, m_last_rd;
  int          m_ph;
  logic [19:0] m_addr;
  logic [15:0] m_data, m_rdd;
  logic [15:0] shadow [logic [19:0]];
  bit          grants[$];

  function automatic logic [15:0] exp_rd(input logic [19:0] a);
    return shadow.exists(a) ? shadow[a] : dflt(a);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_act = 0; m_addr = '0; m_rdd = '0; m_last_rd = 1;
    end else if (m_act) begin
      if (m_ph == ACC) begin
        if (m_wr) shadow[m_addr] = m_data;
        else m_rdd = exp_rd(m_addr);
      end
      if (m_ph == ACC + 1) m_act = 0;
      else m_ph++;
    end else if (wr_req || rd_req) begin
      m_wr      = wr_req && (!rd_req || m_last_rd);
      m_last_rd = !m_wr;
      m_act     = 1;
      m_ph      = 1;
      m_addr    = m_wr ? wr_addr : rd_addr;
      m_data    = wr_data;
      grants.push_back(m_wr);
    end
  endtask

  task automatic check_out();
    bit strobe, e_ce;
    logic [15:0] e_dq;
    strobe = m_act && (m_ph <= ACC);
    e_ce   = !(strobe || (m_act && m_wr));
    e_dq   = (m_act && m_wr) ? m_data : (strobe ? exp_rd(m_addr) : 16'hzzzz);
    chk("ce", ce, e_ce);
    chk("lb", lb, e_ce);
    chk("ub", ub, e_ce);
    chk("we", we, !(strobe && m_wr));
    chk("oe", oe, !(strobe && !m_wr));
    chk("dq", dq, e_dq);
    chk("busy", busy, m_act);
    chk("wr_ack", wr_ack, m_act && m_wr && m_ph == ACC + 1);
    chk("rd_ack", rd_ack, m_act && !m_wr && m_ph == ACC + 1);
    chk("rd_data", rd_data, m_rdd);
    chk("sram_addr", sram_addr, m_addr);
    chk("we_oe_overlap", !we && !oe, 0);
  endtask

  // Requesters
  bit          w_pend, r_pend;
  logic [19:0] w_a, r_a;
  logic [15:0] w_d;

  function automatic logic [19:0] rnd_addr();
    return 20'h30000 | 20'($urandom_range(0, 15));
  endfunction

  task automatic drive();
    wr_req = w_pend; wr_addr = w_a; wr_data = w_d;
    rd_req = r_pend; rd_addr = r_a;
  endtask

  // mode 0: hold only, 1: continuous, 2: random with drops
  task automatic run_cycle(input int mode);
    @(posedge clk);
    model_edge();
    #1;
    check_out();
    if (m_act && m_ph == ACC + 1) begin
      if (m_wr) w_pend = 0; else r_pend = 0;
    end
    if (mode != 0) begin
      if (!w_pend && !(m_act && m_wr) && (mode == 1 || $urandom_range(0, 2) == 0)) begin
        w_pend = 1; w_a = rnd_addr(); w_d = 16'($urandom);
      end
      if (!r_pend && !(m_act && !m_wr) && (mode == 1 || $urandom_range(0, 2) == 0)) begin
        r_pend = 1; r_a = rnd_addr();
      end
      if (mode == 2) begin
        if (w_pend && !(m_act && m_wr) && $urandom_range(0, 19) == 0) w_pend = 0;
        if (r_pend && !(m_act && !m_wr) && $urandom_range(0, 19) == 0) r_pend = 0;
        if (w_pend && m_act && m_wr && m_ph == 1 && $urandom_range(0, 9) == 0) w_pend = 0;
        if (r_pend && m_act && !m_wr && m_ph == 1 && $urandom_range(0, 9) == 0) r_pend = 0;
      end
    end
    drive();
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (!w_pend && !r_pend && !m_act) break;
      run_cycle(0);
    end
    chk("drain_timeout", {w_pend, r_pend, m_act}, 0);
  endtask

  initial begin
    // Reset with both requests held high
    w_pend = 1; w_a = 20'h30001; w_d = 16'h1111;
    r_pend = 1; r_a = 20'h30002;
    drive();
    rst = 1;
    for (int i = 0; i < 3; i++) run_cycle(0);
    rst = 0;
    grants.delete();

    // Continuous dual requests: W,R,W,R...
    for (int i = 0; i < 200 && grants.size() < 8; i++) run_cycle(1);
    chk("cont_timeout", grants.size() >= 8, 1);
    for (int k = 0; k < 8 && k < grants.size(); k++) chk("grant_order", grants[k], (k % 2) == 0);
    drain();

    // Single write then single read of the same word
    w_pend = 1; w_a = 20'h12345; w_d = 16'hBEEF; drive();
    drain();
    r_pend = 1; r_a = 20'h12345; drive();
    drain();
    chk("rd_beef", rd_data, 16'hBEEF);
    run_cycle(0);
    chk("rd_hold", rd_data, 16'hBEEF);

    // Write and read presented together: back-to-back with turnaround
    w_pend = 1; w_a = 20'h30007; w_d = 16'hA55A;
    r_pend = 1; r_a = 20'h30007; drive();
    drain();
    chk("wr_then_rd", rd_data, 16'hA55A);

    // Reset during the first WRITE cycle aborts the access
    w_pend = 1; w_a = 20'hFFFFF; w_d = 16'h1234; drive();
    for (int i = 0; i < 20; i++) begin
      run_cycle(0);
      if (m_act && m_wr && m_ph == 1) break;
    end
    chk("abort_reached", m_act && m_wr && m_ph == 1, 1);
    rst = 1; w_pend = 0; drive();
    run_cycle(0);
    rst = 0;
    chk("abort_we", we, 1);
    chk("abort_ce", ce, 1);
    for (int i = 0; i < 4; i++) run_cycle(0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) run_cycle(2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
